// File: rtl/ps2_key_sequencer_if.sv
// Bundle between ps2_key_sequencer and the ps2_keyboard FIFO / display path.
// The slave modport is the sequencer's view.
interface ps2_key_sequencer_if;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       kb_overflow;
    logic       nextdata_n;
    logic       clr_ovf;
    logic       key_valid;
    logic [7:0] key_scan;
    logic       key_ext;
    logic [7:0] press_bcd;
    logic       press_pulse;
    logic       release_pulse;
    logic       ovf_seen;

    modport master (
        output kb_data, kb_ready, kb_overflow, clr_ovf,
        input  nextdata_n, key_valid, key_scan, key_ext, press_bcd,
               press_pulse, release_pulse, ovf_seen
    );

    modport slave (
        input  kb_data, kb_ready, kb_overflow, clr_ovf,
        output nextdata_n, key_valid, key_scan, key_ext, press_bcd,
               press_pulse, release_pulse, ovf_seen
    );
endinterface

// File: rtl/ps2_key_sequencer.sv
// Drains the PS/2 receiver FIFO, decodes set-2 make/break/E0 sequences,
// tracks the held key and counts presses in two-digit BCD.
module ps2_key_sequencer #(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TO_W        = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    ps2_key_sequencer_if.slave    kb
);

    typedef enum logic [1:0] {S_WAIT, S_POP, S_GAP} state_e;

    state_e           state_q, state_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic             key_valid_q, key_valid_d;
    logic [7:0]       key_scan_q, key_scan_d;
    logic             key_ext_q, key_ext_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       units_q, units_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             ovf_q, ovf_d;
    logic             ext_pend_q, ext_pend_d;
    logic             brk_pend_q, brk_pend_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

    logic consume;
    logic match;
    logic to_run;

    assign consume = (state_q == S_WAIT) && kb.kb_ready;
    assign match   = key_valid_q && (kb.kb_data == key_scan_q) && (ext_pend_q == key_ext_q);
    assign to_run  = (ext_pend_q || brk_pend_q) && (state_q == S_WAIT) && !kb.kb_ready;

    always_comb begin
        state_d      = state_q;
        nextdata_n_d = 1'b1;
        key_valid_d  = key_valid_q;
        key_scan_d   = key_scan_q;
        key_ext_d    = key_ext_q;
        tens_d       = tens_q;
        units_d      = units_q;
        press_d      = 1'b0;
        rel_d        = 1'b0;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        to_cnt_d     = to_cnt_q;

        case (state_q)
            S_WAIT: if (kb.kb_ready) begin
                state_d      = S_POP;
                nextdata_n_d = 1'b0;
            end
            S_POP:   state_d = S_GAP;
            default: state_d = S_WAIT;
        endcase

        if (consume) begin
            to_cnt_d = '0;
            case (kb.kb_data)
                8'hE0: ext_pend_d = 1'b1;
                8'hF0: brk_pend_d = 1'b1;
                8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF: begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
                default: begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                    if (brk_pend_q) begin
                        if (match) begin
                            key_valid_d = 1'b0;
                            rel_d       = 1'b1;
                        end
                    end else if (!match) begin
                        // New make (a matching make is typematic repeat and is ignored)
                        key_scan_d  = kb.kb_data;
                        key_ext_d   = ext_pend_q;
                        key_valid_d = 1'b1;
                        press_d     = 1'b1;
                        if (units_q == 4'd9) begin
                            units_d = 4'd0;
                            tens_d  = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                        end else begin
                            units_d = units_q + 4'd1;
                        end
                    end
                end
            endcase
        end else if (to_run) begin
            // A stale prefix is dropped so a lost byte cannot corrupt the next key
            if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                to_cnt_d   = '0;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end

        if (kb.kb_overflow)  ovf_d = 1'b1;
        else if (kb.clr_ovf) ovf_d = 1'b0;
        else                 ovf_d = ovf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_WAIT;
            nextdata_n_q <= 1'b1;
            key_valid_q  <= 1'b0;
            key_scan_q   <= 8'h00;
            key_ext_q    <= 1'b0;
            tens_q       <= 4'd0;
            units_q      <= 4'd0;
            press_q      <= 1'b0;
            rel_q        <= 1'b0;
            ovf_q        <= 1'b0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            nextdata_n_q <= nextdata_n_d;
            key_valid_q  <= key_valid_d;
            key_scan_q   <= key_scan_d;
            key_ext_q    <= key_ext_d;
            tens_q       <= tens_d;
            units_q      <= units_d;
            press_q      <= press_d;
            rel_q        <= rel_d;
            ovf_q        <= ovf_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    assign kb.nextdata_n    = nextdata_n_q;
    assign kb.key_valid     = key_valid_q;
    assign kb.key_scan      = key_scan_q;
    assign kb.key_ext       = key_ext_q;
    assign kb.press_bcd     = {tens_q, units_q};
    assign kb.press_pulse   = press_q;
    assign kb.release_pulse = rel_q;
    assign kb.ovf_seen      = ovf_q;

endmodule

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
- Controller that drains bytes from the ps2_keyboard receiver FIFO using its data/ready/nextdata_n handshake.
- Parses the PS/2 set-2 make/break/extended protocol and tracks the currently held key.
- Maintains a two-digit BCD press counter and emits per-event pulses.
- Sits between ps2_keyboard and the display/ASCII path; owns the only drive of nextdata_n.

Parameters:
- TIMEOUT_CYC, 1000000, clk cycles a pending E0/F0 prefix may wait for its next byte before being discarded.
- TO_W, 20, width of the prefix timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- kb_data  in  8  ps2_keyboard data output (head of FIFO).
- kb_ready  in  1  ps2_keyboard FIFO non-empty.
- kb_overflow  in  1  ps2_keyboard FIFO overflow indication.
- nextdata_n  out  1  active-low pop strobe to ps2_keyboard; registered.
- clr_ovf  in  1  clears ovf_seen.
- key_valid  out  1  a key is currently held.
- key_scan  out  8  scan code of the held or last-released key.
- key_ext  out  1  held or last key carried the E0 prefix.
- press_bcd  out  8  press count in BCD; [7:4] tens, [3:0] units, range 00..99.
- press_pulse  out  1  one-cycle pulse on a new make.
- release_pulse  out  1  one-cycle pulse on a matching break.
- ovf_seen  out  1  sticky FIFO-overflow flag.

Behaviour:
- Reset values (asynchronous): nextdata_n=1, key_valid=0, key_scan=00, key_ext=0, press_bcd=00, press_pulse=0, release_pulse=0, ovf_seen=0. Prefix flags, timeout counter and FSM also clear, FSM to WAIT.
- A reset asserted mid-handshake aborts it; nextdata_n returns high immediately.

Handshake FSM:
- WAIT: if kb_ready=1 at edge N, consume kb_data at edge N, drive nextdata_n=0, go POP.
- POP: nextdata_n=0 for exactly this one cycle; at the next edge drive nextdata_n=1, go GAP.
- GAP: one idle cycle so kb_ready reflects the advanced read pointer; go WAIT.
- Throughput: at most one byte per 3 cycles. nextdata_n is never low outside POP.

Byte decode (applied at edge N, results visible after edge N):
- E0: set ext_pend; no output change.
- F0: set brk_pend; no output change.
- 00, AA, E1, FA, FE, FF: discarded; both prefix flags cleared.
- Other code c with brk_pend=1 (break):
  - If key_valid=1, c==key_scan and ext_pend==key_ext: key_valid<=0, release_pulse=1.
  - Otherwise ignored.
  - Both prefix flags are cleared in either case.
- Other code c with brk_pend=0 (make):
  - Typematic repeat: if key_valid=1, c==key_scan and ext_pend==key_ext, no output change.
  - Otherwise: key_scan<=c, key_ext<=ext_pend, key_valid<=1, press_pulse=1, press_bcd increments.
  - Both prefix flags are cleared in either case.
- Pulse timing: press_pulse and release_pulse are high for the single cycle after edge N, coincident with POP.

BCD counter:
- Units 9 -> 0 with carry into tens.
- 99 -> 00 wrap; no other indication.

Prefix timeout:
- The counter runs while either prefix flag is set and the FSM is in WAIT with kb_ready=0.
- On reaching TIMEOUT_CYC, both flags clear and the counter resets.
- The counter resets on every consumed byte.

Overflow:
- kb_overflow=1 sets ovf_seen; clr_ovf=1 clears it.
- If both occur in the same cycle, set wins.
- Overflow does not alter decode.

Test Plan:
- Reset, then FIFO bytes 1C,F0,1C -> key_valid 1 then 0, key_scan=1C, key_ext=0, press_bcd=01, one press_pulse, one release_pulse; nextdata_n low exactly 3 single cycles, each spaced >=3 cycles.
- Bytes E0,75,E0,F0,75 -> key_ext=1, key_scan=75, press_bcd=01; release only on the E0-prefixed break. A plain F0,75 in place of E0,F0,75 leaves key_valid=1.
- Typematic 1C,1C,1C,F0,1C -> press_bcd=01, one press_pulse.
- 100 press/release pairs of 1B -> press_bcd walks 09->10 and 99->00, ending at 00.
- F0 then idle for TIMEOUT_CYC cycles (run with TIMEOUT_CYC=16), then 1C -> treated as a make: press_pulse=1, key_valid=1.
- kb_overflow and clr_ovf asserted in the same cycle -> ovf_seen=1; clr_ovf alone -> 0. rst asserted during POP -> nextdata_n=1 and all outputs at reset values asynchronously.
